// File: rtl/pipe_seq_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_seq_ctrl
//
// Sequencing controller for the 3-stage pipeline. It gates PC advance and
// the stage-1 -> stage-2 register, and injects NOP bubbles (8'h00) into
// stage 2 for taken control transfers, load-use hazards, and halt or
// single-step.
//
// Parameters
//   FLUSH_CYCLES  bubbles after a taken jump/call/return (1..15)
//   MEM_STALL     bubbles per load-use hazard (1..15)
//   CNT_W         width of the bubble down-counter; it must hold both
//                 FLUSH_CYCLES and MEM_STALL
//
// Ports
//   clk           system clock; all state changes on posedge
//   rst_n         synchronous reset, active-low
//   id_opcode     opcode in stage 1, about to be registered into stage 2
//   ex_opcode     opcode held in the stage-2 register
//   ex_load_pc    execute stage takes a control transfer this cycle
//   ex_rd         execute stage performs a data-memory read
//   halt_req      level request to halt the pipeline
//   step          one-cycle pulse; issue one instruction while halted
//   pc_en         PC/fetch may advance
//   ifid_en       stage-2 register load enable
//   bubble        stage-2 register loads 8'h00 instead of id_opcode
//   state         00 RUN, 01 STALL, 10 FLUSH, 11 HALT
//   stall_cycles  saturating count of cycles with pc_en=0 or bubble=1
// ---------------------------------------------------------------------------
module pipe_seq_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_STALL    = 1,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  id_opcode,
    input  logic [7:0]  ex_opcode,
    input  logic        ex_load_pc,
    input  logic        ex_rd,
    input  logic        halt_req,
    input  logic        step,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        bubble,
    output logic [1:0]  state,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        S_RUN   = 2'b00,
        S_STALL = 2'b01,
        S_FLUSH = 2'b10,
        S_HALT  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] FLUSH_LD = CNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] STALL_LD = CNT_W'(MEM_STALL);
    localparam logic [15:0]      SAT_MAX  = 16'hFFFF;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_active_q, step_active_d;
    logic [15:0]      stall_q;

    // ---------------------------------------------------------------------
    // Load-use hazard detect.
    // LDA rn is 0111_0_nnn with nnn != 0 (nnn = 0 is a different form that
    // does not write a register); POP rn is 0111_1_nnn. The consumer in
    // stage 1 must be a register-using opcode (upper nibble non-zero) that
    // names the same register in its low three bits.
    // ---------------------------------------------------------------------
    logic ex_is_lda;
    logic ex_is_pop;
    logic load_use;

    always_comb begin
        ex_is_lda = (ex_opcode[7:3] == 5'b01110) && (ex_opcode[2:0] != 3'b000);
        ex_is_pop = (ex_opcode[7:3] == 5'b01111);
        load_use  = ex_rd
                  && (ex_is_lda || ex_is_pop)
                  && (id_opcode[7:4] != 4'b0000)
                  && (id_opcode[2:0] == ex_opcode[2:0]);
    end

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_RUN;
            cnt_q         <= '0;
            step_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            step_active_q <= step_active_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic.
    // step_active only survives the single RUN cycle granted by a step; any
    // other transition clears it so a later RUN is not mistaken for a step.
    // ---------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        step_active_d = 1'b0;

        if (ex_load_pc) begin
            // A taken transfer flushes from any state and restarts an
            // in-progress flush or stall.
            state_d = S_FLUSH;
            cnt_d   = FLUSH_LD;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (load_use) begin
                        state_d = S_STALL;
                        cnt_d   = STALL_LD;
                    end else if (halt_req || step_active_q) begin
                        state_d = S_HALT;
                    end
                end
                S_STALL, S_FLUSH: begin
                    // The cnt <= 1 test also recovers from a zero count
                    // instead of wrapping round through the counter.
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = halt_req ? S_HALT : S_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q - CNT_W'(1);
                    end
                end
                S_HALT: begin
                    if (!halt_req) begin
                        state_d = S_RUN;
                    end else if (step) begin
                        state_d       = S_RUN;
                        step_active_d = 1'b1;
                    end
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Moore output decode. While reset is held, stage 2 is flooded with
    // NOPs and fetch is frozen, whatever the register holds.
    // ---------------------------------------------------------------------
    always_comb begin
        pc_en   = 1'b1;
        ifid_en = 1'b1;
        bubble  = 1'b0;
        if (!rst_n) begin
            pc_en  = 1'b0;
            bubble = 1'b1;
        end else begin
            unique case (state_q)
                S_RUN:   ;
                S_STALL: begin pc_en = 1'b0; bubble = 1'b1; end
                S_FLUSH: begin bubble = 1'b1; end
                S_HALT:  begin pc_en = 1'b0; bubble = 1'b1; end
                default: ;
            endcase
        end
    end

    assign state = state_q;

    // ---------------------------------------------------------------------
    // Lost-cycle counter; saturates instead of wrapping.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if ((!pc_en || bubble) && (stall_q != SAT_MAX)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
module tb_pipe_seq_ctrl;

    localparam int F = 2;   // FLUSH_CYCLES
    localparam int M = 1;   // MEM_STALL

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  id_opcode, ex_opcode;
    logic        ex_load_pc, ex_rd, halt_req, step;
    logic        pc_en, ifid_en, bubble;
    logic [1:0]  state;
    logic [15:0] stall_cycles;

    int n_vec = 0;
    int n_err = 0;

    pipe_seq_ctrl #(.FLUSH_CYCLES(F), .MEM_STALL(M), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_opcode(id_opcode), .ex_opcode(ex_opcode),
        .ex_load_pc(ex_load_pc), .ex_rd(ex_rd),
        .halt_req(halt_req), .step(step),
        .pc_en(pc_en), .ifid_en(ifid_en), .bubble(bubble),
        .state(state), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: tracks the pipeline's mode, how many bubbles are
    // still owed, and whether the current run cycle is a granted step.
    // ------------------------------------------------------------------
    int  m_mode;       // 0 run, 1 stall, 2 flush, 3 halt
    int  m_owed;       // bubbles still to insert in stall/flush
    bit  m_stepping;
    int  m_lost;
    bit  m_valid = 0;

    function automatic bit hazard(input logic [7:0] idop, input logic [7:0] exop, input logic rd);
        bit writes_reg;
        writes_reg = (exop >= 8'h71 && exop <= 8'h77) || (exop >= 8'h78 && exop <= 8'h7F);
        return rd && writes_reg && (idop >= 8'h10) && ((idop % 8) == (exop % 8));
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode = 0; m_owed = 0; m_stepping = 0; m_lost = 0; m_valid = 1;
        end else if (m_valid) begin
            if (m_mode != 0 && m_lost < 65535) m_lost++;
            if (ex_load_pc) begin
                m_mode = 2; m_owed = F; m_stepping = 0;
            end else if (m_mode == 0) begin
                if (hazard(id_opcode, ex_opcode, ex_rd)) begin
                    m_mode = 1; m_owed = M;
                end else if (halt_req || m_stepping) begin
                    m_mode = 3;
                end
                m_stepping = 0;
            end else if (m_mode == 3) begin
                if (!halt_req) m_mode = 0;
                else if (step) begin m_mode = 0; m_stepping = 1; end
            end else begin
                m_owed--;
                if (m_owed == 0) m_mode = halt_req ? 3 : 0;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            logic [2:0] exp_o;
            if (!rst_n)           exp_o = 3'b011;
            else if (m_mode == 0) exp_o = 3'b110;
            else if (m_mode == 2) exp_o = 3'b111;
            else                  exp_o = 3'b011;
            n_vec++;
            if ({pc_en, ifid_en, bubble} != exp_o) begin
                n_err++;
                $display("FAIL cmp_outs t=%0t got pc/ifid/bub=%b want %b", $time, {pc_en, ifid_en, bubble}, exp_o);
            end
            n_vec++;
            if (state != 2'(m_mode)) begin
                n_err++;
                $display("FAIL cmp_state t=%0t got %0d want %0d", $time, state, m_mode);
            end
            n_vec++;
            if (stall_cycles != 16'(m_lost)) begin
                n_err++;
                $display("FAIL cmp_stall_cycles t=%0t got %0d want %0d", $time, stall_cycles, m_lost);
            end
        end
    end

    // Hand-computed literal checks.
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk); #1;
    endtask

    task automatic clr();
        id_opcode = 8'h00; ex_opcode = 8'h00; ex_rd = 1'b0; ex_load_pc = 1'b0; step = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; halt_req = 1'b0; clr();
        repeat (3) edge1();
        @(negedge clk);
        chk("rst_outs", {13'd0, pc_en, ifid_en, bubble}, 16'b011);
        chk("rst_state", {14'd0, state}, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("run_outs", {13'd0, pc_en, ifid_en, bubble}, 16'b110);
        chk("run_state", {14'd0, state}, 16'd0);
        chk("run_cnt0", stall_cycles, 16'd0);

        // Load-use: LDA r3 then ADA r3 -> one stall cycle.
        edge1();
        ex_opcode = 8'h73; ex_rd = 1'b1; id_opcode = 8'h83;
        edge1(); clr();
        @(negedge clk);
        chk("lu_state", {14'd0, state}, 16'd1);
        chk("lu_outs", {13'd0, pc_en, ifid_en, bubble}, 16'b011);
        edge1(); @(negedge clk);
        chk("lu_back_run", {14'd0, state}, 16'd0);
        chk("lu_cnt", stall_cycles, 16'd1);

        // Different register -> no stall.
        ex_opcode = 8'h73; ex_rd = 1'b1; id_opcode = 8'h84;
        edge1(); clr();
        @(negedge clk);
        chk("nolu_state", {14'd0, state}, 16'd0);
        // POP r5 with a matching consumer, and LDA with nnn=0 (no hazard).
        ex_opcode = 8'h7D; ex_rd = 1'b1; id_opcode = 8'h25;
        edge1(); clr(); edge1();
        ex_opcode = 8'h70; ex_rd = 1'b1; id_opcode = 8'h20;
        edge1(); clr();
        @(negedge clk);
        chk("lda0_state", {14'd0, state}, 16'd0);

        // Taken jump -> two flush cycles.
        ex_load_pc = 1'b1;
        edge1(); clr();
        @(negedge clk);
        chk("fl_state1", {14'd0, state}, 16'd2);
        chk("fl_outs", {13'd0, pc_en, ifid_en, bubble}, 16'b111);
        edge1(); @(negedge clk);
        chk("fl_state2", {14'd0, state}, 16'd2);
        edge1(); @(negedge clk);
        chk("fl_done", {14'd0, state}, 16'd0);

        // Jump coinciding with a load-use -> flush wins.
        ex_load_pc = 1'b1; ex_opcode = 8'h73; ex_rd = 1'b1; id_opcode = 8'h83;
        edge1(); clr();
        @(negedge clk);
        chk("fllu_state", {14'd0, state}, 16'd2);
        repeat (2) edge1();
        // Flush restarted mid-flush.
        ex_load_pc = 1'b1; edge1(); clr();
        edge1(); ex_load_pc = 1'b1; edge1(); clr();
        repeat (3) edge1();

        // Halt, step, release.
        halt_req = 1'b1;
        edge1(); @(negedge clk);
        chk("halt_state", {14'd0, state}, 16'd3);
        step = 1'b1; edge1(); step = 1'b0;
        @(negedge clk);
        chk("step_run", {13'd0, pc_en, ifid_en, bubble}, 16'b110);
        edge1(); @(negedge clk);
        chk("step_rehalt", {14'd0, state}, 16'd3);
        halt_req = 1'b0;
        edge1(); @(negedge clk);
        chk("unhalt", {14'd0, state}, 16'd0);

        // Step that issues a taken jump -> flush then halt.
        halt_req = 1'b1; edge1();
        step = 1'b1; edge1(); step = 1'b0;
        ex_load_pc = 1'b1; edge1(); ex_load_pc = 1'b0;
        @(negedge clk);
        chk("stepjmp_fl", {14'd0, state}, 16'd2);
        repeat (2) edge1();
        @(negedge clk);
        chk("stepjmp_halt", {14'd0, state}, 16'd3);

        // Step ignored outside HALT; halt dropped mid-flush -> RUN afterwards.
        halt_req = 1'b0; edge1();
        step = 1'b1; edge1(); step = 1'b0;
        halt_req = 1'b1; ex_load_pc = 1'b1; edge1(); ex_load_pc = 1'b0;
        halt_req = 1'b0; repeat (2) edge1();
        @(negedge clk);
        chk("flush_unhalt", {14'd0, state}, 16'd0);

        // Saturation.
        halt_req = 1'b1;
        repeat (66000) edge1();
        @(negedge clk);
        chk("sat", stall_cycles, 16'hFFFF);
        halt_req = 1'b0;
        edge1();

        // Reset mid-flush.
        ex_load_pc = 1'b1; edge1(); clr();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstfl_outs", {13'd0, pc_en, ifid_en, bubble}, 16'b011);
        edge1(); rst_n = 1'b1;
        @(negedge clk);
        chk("rstfl_state", {14'd0, state}, 16'd0);
        chk("rstfl_cnt", stall_cycles, 16'd0);
        repeat (2) edge1();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_seq_ctrl.md
Name: pipe_seq_ctrl

Overview:
- Sequencing controller for the 3-stage pipeline. It drives the PC advance enable and the stage-1→stage-2 register enable, and injects NOP bubbles (opcode 8'h00) into stage 2.
- It handles taken-control-transfer flush, load-use stalls, and halt/single-step.
- It sits beside the stage-2/stage-3 control logic. It observes the stage-1 opcode, the stage-2 opcode and that stage's L_PC/RD decisions, then gates the fetch path.

Parameters:
- FLUSH_CYCLES, 1, bubbles inserted after a taken jump/call/return (1..15)
- MEM_STALL, 1, bubbles inserted per load-use hazard (1..15)
- CNT_W, 4, width of the internal down-counter

Ports:
- clk  input  1  system clock, all state on posedge
- rst_n  input  1  synchronous reset, active-low
- id_opcode  input  8  opcode currently in stage 1 (about to be registered into stage 2)
- ex_opcode  input  8  opcode held in the stage-2 register (being decoded for execute)
- ex_load_pc  input  1  execute stage loads the PC this cycle (taken JU*/JC*/CU*/CC*/RT*)
- ex_rd  input  1  execute stage performs a data-memory read
- halt_req  input  1  level; request pipeline halt
- step  input  1  one-cycle pulse; issue one instruction while halted
- pc_en  output  1  PC/fetch may advance
- ifid_en  output  1  stage-2 register load enable
- bubble  output  1  stage-2 register loads 8'h00 instead of id_opcode
- state  output  2  00 RUN, 01 STALL, 10 FLUSH, 11 HALT
- stall_cycles  output  16  saturating count of cycles with pc_en=0 or bubble=1

Behaviour:
- Reset (rst_n=0 at posedge): state←RUN, cnt←0, step_active←0, stall_cycles←0.
  - While rst_n=0, outputs are forced combinationally to pc_en=0, ifid_en=1, bubble=1 (NOP flood).
- Outputs are a Moore decode of state. They change only after posedge:
  - RUN: pc_en=1, ifid_en=1, bubble=0
  - STALL: pc_en=0, ifid_en=1, bubble=1. The instruction stays in stage 1; stage 2 gets a NOP.
  - FLUSH: pc_en=1, ifid_en=1, bubble=1. The wrong-path instruction is replaced by a NOP.
  - HALT: pc_en=0, ifid_en=1, bubble=1. Execute sees only NOPs, so nothing re-executes.
- Load-use hazard (LU), all terms true:
  - ex_rd=1
  - ex_opcode is LDA_rn (0111_0_nnn, nnn≠000) or POP_rn (0111_1_nnn)
  - id_opcode[7:4]≠4'b0000
  - id_opcode[2:0]=ex_opcode[2:0]
- Next-state priority, evaluated each posedge:
  1. ex_load_pc=1 → FLUSH, cnt←FLUSH_CYCLES. This applies from any state, and overrides LU, halt and step.
  2. In RUN with LU → STALL, cnt←MEM_STALL.
  3. In RUN with halt_req=1 → HALT. If step_active=1 → HALT, and step_active←0.
  4. Otherwise RUN.
- STALL/FLUSH: cnt decrements each cycle. When cnt=1 the next state is HALT if halt_req=1, else RUN.
  - A new ex_load_pc during STALL or FLUSH restarts FLUSH with cnt←FLUSH_CYCLES.
  - LU during FLUSH is ignored, because stage 2 holds a bubble.
- HALT:
  - halt_req=0 → RUN.
  - step=1 while halt_req=1 → RUN for exactly one cycle with step_active←1, then back to HALT per rule 3.
  - step in any other state is ignored (not queued).
- Latency: ex_load_pc/LU sampled at edge t gives outputs valid from t+1. A flush lasts exactly FLUSH_CYCLES cycles; a stall lasts exactly MEM_STALL cycles.
- stall_cycles: +1 each cycle that rst_n=1 and (pc_en=0 or bubble=1). It saturates at 16'hFFFF and does not wrap.
- halt_req deasserted mid-FLUSH: the flush still completes, then the state returns to RUN.

Test Plan:
- Reset held 3 cycles, then released → pc_en=0/ifid_en=1/bubble=1 during reset; state=00, outputs 1/1/0 on the first cycle after; stall_cycles=0.
- ex_opcode=8'h73 (LDA r3), ex_rd=1, id_opcode=8'h83 (ADA r3) for one cycle, MEM_STALL=1 → exactly one cycle of state=01, pc_en=0, bubble=1, then RUN; stall_cycles=1. Repeat with id_opcode=8'h84 → no stall.
- ex_load_pc=1 pulse with FLUSH_CYCLES=2 → state=10 for 2 cycles with pc_en=1, bubble=1, then RUN. Same pulse coinciding with LU → FLUSH wins, and no STALL cycle occurs.
- halt_req=1 in RUN → HALT next cycle. Then a step pulse → one RUN cycle (pc_en=1, bubble=0), then HALT. Then halt_req=0 → RUN.
- Step issues a taken jump: ex_load_pc=1 during the RUN step cycle with halt_req=1 → FLUSH for FLUSH_CYCLES cycles, then HALT.
- Force stall_cycles near the limit (halt for 65536+ cycles) → stall_cycles holds 16'hFFFF. rst_n=0 mid-FLUSH → next state RUN, cnt=0, counter cleared.
